fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage of the pipelined MIPS core: owns the PC, issues requests to instruction memory, and loads the IF/ID pipeline register. It sits directly upstream of the hazard unit. It consumes the hazard unit's PC and IF/ID write enables, and it produces the ID-stage source-register fields and read-active flag that the hazard unit compares against the EX destination. Branch redirects from EX flush the stage.

## Interface
- `PC_W`, 16, PC and instruction-address width
- `INSTR_W`, 16, instruction width; format is `[15:12]` opcode, `[11:8]` rs, `[7:4]` rt, `[3:0]` rd
- `RESET_PC`, 0, PC value after reset
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `pc_wr_en`  in  1  from hazard unit; 0 = freeze PC
- `ifid_wr_en`  in  1  from hazard unit; 0 = freeze IF/ID
- `branch_taken`  in  1  redirect/flush request from EX
- `branch_target`  in  PC_W  redirect address
- `imem_req`  out  1  fetch request
- `imem_addr`  out  PC_W  fetch address, equal to the current PC
- `imem_ready`  in  1  `imem_data` is valid for `imem_addr` this cycle
- `imem_data`  in  INSTR_W  fetched instruction
- `id_valid`  out  1  IF/ID holds a real instruction
- `id_instr`  out  INSTR_W  IF/ID instruction, NOP (all zero) when invalid
- `id_pc_plus1`  out  PC_W  address of the instruction plus 1
- `id_rs`  out  4  `id_instr[11:8]`, to hazard unit ID reg1
- `id_rt`  out  4  `id_instr[7:4]`, to hazard unit ID reg2
- `id_reads`  out  1  `id_valid && opcode != 0`, to hazard unit READ ACTIVE

## Operation
- `advance = pc_wr_en & ifid_wr_en`. An instruction is consumed only when `advance` is high.
- FSM states:
  - REQ: `imem_req=1`.
  - HELD: `imem_req=0`; a fetched instruction sits in a 1-entry hold buffer (`hold_instr`, `hold_pc`).
- Priority order each cycle: `rst` > `branch_taken` > `advance` > hold.
- `branch_taken`, any state:
  - PC <= `branch_target`.
  - IF/ID <= bubble (`id_valid=0`, `id_instr=0`), regardless of `ifid_wr_en`.
  - Hold buffer and any `imem_data` this cycle are discarded.
  - Next state is REQ.
- REQ with `imem_ready`:
  - If `advance`: IF/ID <= {1, `imem_data`, PC+1}, PC <= PC+1, stay in REQ.
  - Otherwise: capture into the hold buffer and go to HELD. If `ifid_wr_en=1`, IF/ID <= bubble.
- REQ without `imem_ready`: PC unchanged. If `ifid_wr_en=1`, IF/ID <= bubble; otherwise IF/ID holds.
- HELD:
  - If `advance`: IF/ID <= {1, `hold_instr`, `hold_pc`+1}, PC <= PC+1, go to REQ.
  - Otherwise: IF/ID <= bubble if `ifid_wr_en=1`, else IF/ID holds.
- PC arithmetic is modulo 2^`PC_W`; `0xFFFF+1` wraps to 0 with no flag.
- `imem_addr` changes only on an accepted fetch or on a branch. Memory indexes combinationally; a branch during a wait abandons the old request.

## Timing
- Reset values: PC=`RESET_PC`, state=REQ, `id_valid=0`, `id_instr=0`, `id_pc_plus1=0`, hold buffer=0.
- `imem_req` is 1 from the first edge after `rst` falls. While `rst` is high, `imem_req=0`.
- Zero-wait memory (`imem_ready` tied high) gives one instruction per cycle. An instruction fetched at edge N is visible on the `id_*` outputs after edge N (1-cycle latency).
- `id_rs`, `id_rt`, `id_reads` are combinational from the IF/ID register; there is no extra latency to the hazard unit.
- A hazard-unit stall of k cycles (`advance=0`, `ifid_wr_en=0`) freezes `id_*` for exactly k cycles. No instruction is lost or duplicated.
- A branch flush costs one bubble in ID. Fetch of the target starts the next cycle.
- `rst` asserted mid-wait or in HELD returns all state to reset values immediately (asynchronous).

## Structure
- The shared package `mips_pkg` holds `NOP_INSTR`, the opcode field position, the register-field width (4), and the state encoding (REQ=0, HELD=1).
- Sub-module `if_id_reg` holds the IF/ID register with load, hold, and flush. `fetch_stage` keeps the PC, FSM, and hold buffer.

## Test plan
- Reset, `RESET_PC`=0x0010, `imem_ready=1` -> `imem_addr` sequence 0x0010, 0x0011, 0x0012, …; `id_valid=1` from the 2nd edge.
- Load hazard: `id_instr`=0x1230, then `pc_wr_en=ifid_wr_en=0` for 2 cycles -> `id_instr` stays 0x1230, `id_rs`=2, `id_rt`=3, `id_reads`=1, PC stays fixed. The next instruction arrives on release with no gap or duplicate.
- Wait states: `imem_ready` low for 3 cycles, `ifid_wr_en=1` -> 3 bubbles (`id_valid=0`, `id_reads=0`), then the instruction, with `id_pc_plus1` correct.
- `branch_taken` to 0x0100 while in HELD -> hold buffer dropped, `id_valid=0` for 1 cycle, next `imem_addr`=0x0100.
- PC=0xFFFF accepted -> `id_pc_plus1`=0x0000 and next `imem_addr`=0x0000.
- `rst` pulsed mid-wait -> all outputs take reset values on the same edge, without waiting for a clock.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants and fetch FSM encoding for the MIPS pipeline
package mips_pkg;

  localparam int REG_W   = 4;
  localparam int OPC_W   = 4;
  localparam int OPC_LSB = 12;
  localparam int RS_LSB  = 8;
  localparam int RT_LSB  = 4;

  localparam logic [15:0] NOP_INSTR = 16'h0000;

  typedef enum logic {
    ST_REQ  = 1'b0,
    ST_HELD = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with load, hold and flush
module if_id_reg
  import mips_pkg::*;
#(
  parameter int PC_W    = 16,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               load,
  input  logic [INSTR_W-1:0] load_instr,
  input  logic [PC_W-1:0]    load_pc_plus1,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    pc_plus1
);

  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    pc_plus1_q, pc_plus1_d;

  // Flush wins over load so a bubble is always clean
  always_comb begin
    valid_d    = valid_q;
    instr_d    = instr_q;
    pc_plus1_d = pc_plus1_q;
    if (flush) begin
      valid_d    = 1'b0;
      instr_d    = INSTR_W'(NOP_INSTR);
      pc_plus1_d = '0;
    end else if (load) begin
      valid_d    = 1'b1;
      instr_d    = load_instr;
      pc_plus1_d = load_pc_plus1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      instr_q    <= INSTR_W'(NOP_INSTR);
      pc_plus1_q <= '0;
    end else begin
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      pc_plus1_q <= pc_plus1_d;
    end
  end

  assign valid    = valid_q;
  assign instr    = instr_q;
  assign pc_plus1 = pc_plus1_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: PC, request FSM, hold buffer, IF/ID load
module fetch_stage
  import mips_pkg::*;
#(
  parameter int               PC_W     = 16,
  parameter int               INSTR_W  = 16,
  parameter logic [PC_W-1:0]  RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pc_wr_en,
  input  logic               ifid_wr_en,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               id_valid,
  output logic [INSTR_W-1:0] id_instr,
  output logic [PC_W-1:0]    id_pc_plus1,
  output logic [REG_W-1:0]   id_rs,
  output logic [REG_W-1:0]   id_rt,
  output logic               id_reads
);

  fetch_state_e       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] hold_instr_q, hold_instr_d;
  logic [PC_W-1:0]    hold_pc_q, hold_pc_d;

  logic               advance;
  logic               ifid_flush;
  logic               ifid_load;
  logic [INSTR_W-1:0] ifid_instr;
  logic [PC_W-1:0]    ifid_pc_plus1;

  assign advance = pc_wr_en & ifid_wr_en;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    hold_instr_d  = hold_instr_q;
    hold_pc_d     = hold_pc_q;
    ifid_flush    = 1'b0;
    ifid_load     = 1'b0;
    ifid_instr    = imem_data;
    ifid_pc_plus1 = pc_q + PC_W'(1);

    if (branch_taken) begin
      // Redirect drops both the in-flight response and anything held
      state_d      = ST_REQ;
      pc_d         = branch_target;
      hold_instr_d = '0;
      hold_pc_d    = '0;
      ifid_flush   = 1'b1;
    end else begin
      unique case (state_q)
        ST_REQ: begin
          if (imem_ready && advance) begin
            ifid_load = 1'b1;
            pc_d      = pc_q + PC_W'(1);
          end else if (imem_ready) begin
            hold_instr_d = imem_data;
            hold_pc_d    = pc_q;
            state_d      = ST_HELD;
            ifid_flush   = ifid_wr_en;
          end else begin
            ifid_flush = ifid_wr_en;
          end
        end
        ST_HELD: begin
          if (advance) begin
            ifid_load     = 1'b1;
            ifid_instr    = hold_instr_q;
            ifid_pc_plus1 = hold_pc_q + PC_W'(1);
            pc_d          = pc_q + PC_W'(1);
            state_d       = ST_REQ;
          end else begin
            ifid_flush = ifid_wr_en;
          end
        end
        default: state_d = ST_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_REQ;
      pc_q         <= RESET_PC;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
    end
  end

  if_id_reg #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_if_id_reg (
    .clk           (clk),
    .rst           (rst),
    .flush         (ifid_flush),
    .load          (ifid_load),
    .load_instr    (ifid_instr),
    .load_pc_plus1 (ifid_pc_plus1),
    .valid         (id_valid),
    .instr         (id_instr),
    .pc_plus1      (id_pc_plus1)
  );

  // Reset state is REQ, so the request must be masked while rst is held
  assign imem_req  = (state_q == ST_REQ) && !rst;
  assign imem_addr = pc_q;

  assign id_rs    = id_instr[RS_LSB +: REG_W];
  assign id_rt    = id_instr[RT_LSB +: REG_W];
  assign id_reads = id_valid && (id_instr[OPC_LSB +: OPC_W] != '0);

endmodule
